// File: rtl/uno_pkg.sv
// Shared UNO card types, constants and helpers.
// Imported by the player hand datapath, its deck interface and the legality
// checker. No ports; holds the card layout, the draw command encodings and
// the hand controller state type.
package uno_pkg;

  localparam int MAX_CARDS_DEF = 32;

  typedef struct packed {
    logic [1:0] color;
    logic [3:0] value;
  } card_t;

  // Colors
  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BLUE   = 2'd3;

  // Special values; 0..9 are number cards
  localparam logic [3:0] SKIP    = 4'd10;
  localparam logic [3:0] REVERSE = 4'd11;
  localparam logic [3:0] DRAW2   = 4'd12;
  localparam logic [3:0] WILD    = 4'd13;
  localparam logic [3:0] WILD4   = 4'd14;

  // One-hot draw commands
  localparam logic [2:0] DRAW1  = 3'b001;
  localparam logic [2:0] DRAW2C = 3'b010;
  localparam logic [2:0] DRAW4  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RECV  = 2'd2,
    S_SHIFT = 2'd3
  } hand_state_e;

  // Number of cards a draw command asks for; 0 for anything not one-hot.
  function automatic logic [2:0] draw_count(input logic [2:0] code);
    logic [2:0] n;
    case (code)
      DRAW1:   n = 3'd1;
      DRAW2C:  n = 3'd2;
      DRAW4:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/player_hand_if.sv
// Deck draw channel between one player hand and the deck.
// Handshake: the hand (master) raises a one-hot o_draw and holds it stable
// until every requested card has arrived. The deck (slave) reports idle on
// i_deck_done and delivers each card by pulsing i_drawn for one cycle with
// i_card valid in that same cycle. There is no backpressure on i_drawn.
//   o_draw      hand -> deck  one-hot request (001/010/100), 000 = none
//   i_deck_done deck -> hand  deck idle/ready
//   i_drawn     deck -> hand  one-cycle strobe, i_card valid
//   i_card      deck -> hand  card {color, value}
interface player_hand_if;
  logic [2:0]      o_draw;
  logic            i_deck_done;
  logic            i_drawn;
  uno_pkg::card_t  i_card;

  modport master (output o_draw, input i_deck_done, input i_drawn, input i_card);
  modport slave  (input o_draw, output i_deck_done, output i_drawn, output i_card);
endinterface

// File: rtl/player_hand_card_match.sv
// card_match: combinational legality check of a candidate card against the
// top discard card. Shared with the AI player logic.
//   c_i     candidate card
//   t_i     top discard card (color already replaced by chosen color on wild)
//   valid_i candidate actually exists in the hand
//   legal_o candidate may be played
module card_match
  import uno_pkg::*;
(
  input  card_t c_i,
  input  card_t t_i,
  input  logic  valid_i,
  output logic  legal_o
);

  assign legal_o = valid_i &&
                   ((c_i.color == t_i.color) ||
                    (c_i.value == t_i.value) ||
                    (c_i.value == WILD)      ||
                    (c_i.value == WILD4));

endmodule

// File: rtl/player_hand.sv
// player_hand: one player's hand of UNO cards.
// Requests cards from the deck, stores them compacted from index 0, checks
// and executes plays against the top discard card, and closes the gap left
// by a played card with a one-slot-per-cycle shift-down.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   deck                  deck draw channel (master side)
//   i_req_draw            draw command: 001/010/100, others ignored
//   i_play, i_sel         play strobe and selected hand index
//   i_top_card            top discard card
//   o_sel_card            hand[i_sel], 0 when i_sel is beyond the hand
//   o_played_card         last accepted card
//   o_play_ok/o_play_err  one-cycle play verdict pulses
//   o_draw_err            one-cycle pulse: draw would overflow the hand
//   o_busy                controller not idle
//   o_count, o_uno, o_empty  hand size and flags
//   o_dbg_state           controller state for observation
module player_hand
  import uno_pkg::*;
#(
  parameter int MAX_CARDS = MAX_CARDS_DEF,
  parameter int IDX_W     = $clog2(MAX_CARDS),
  parameter int CNT_W     = $clog2(MAX_CARDS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  player_hand_if.master     deck,
  input  logic [2:0]        i_req_draw,
  input  logic              i_play,
  input  logic [IDX_W-1:0]  i_sel,
  input  card_t             i_top_card,
  output card_t             o_sel_card,
  output card_t             o_played_card,
  output logic              o_play_ok,
  output logic              o_play_err,
  output logic              o_draw_err,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_uno,
  output logic              o_empty,
  output hand_state_e       o_dbg_state
);

  hand_state_e       state_q;
  card_t             hand_q [MAX_CARDS];
  logic [CNT_W-1:0]  count_q;
  logic [2:0]        need_q;
  logic [2:0]        draw_q;
  logic [IDX_W-1:0]  k_q;
  card_t             played_q;
  logic              play_ok_q;
  logic              play_err_q;
  logic              draw_err_q;

  logic [CNT_W-1:0]  sel_ext;
  logic              sel_valid;
  card_t             sel_card;
  logic              legal;
  logic [2:0]        draw_n;
  logic [CNT_W:0]    draw_sum;
  logic              draw_fits;
  logic              sel_is_last;
  logic              shift_last;

  assign sel_ext   = CNT_W'(i_sel);
  assign sel_valid = sel_ext < count_q;
  assign sel_card  = hand_q[i_sel];

  card_match u_match (
    .c_i     (sel_card),
    .t_i     (i_top_card),
    .valid_i (sel_valid),
    .legal_o (legal)
  );

  // Sum is one bit wider than count so the overflow compare never wraps.
  assign draw_n      = draw_count(i_req_draw);
  assign draw_sum    = {1'b0, count_q} + (CNT_W+1)'(draw_n);
  assign draw_fits   = draw_sum <= (CNT_W+1)'(MAX_CARDS);
  assign sel_is_last = sel_ext == (count_q - CNT_W'(1));
  // count_q already holds the reduced count while shifting.
  assign shift_last  = CNT_W'(k_q) == (count_q - CNT_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < MAX_CARDS; i++) hand_q[i] <= '0;
      count_q    <= '0;
      need_q     <= '0;
      draw_q     <= '0;
      k_q        <= '0;
      played_q   <= '0;
      play_ok_q  <= 1'b0;
      play_err_q <= 1'b0;
      draw_err_q <= 1'b0;
    end else begin
      play_ok_q  <= 1'b0;
      play_err_q <= 1'b0;
      draw_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A valid draw command wins over a simultaneous play.
          if (draw_n != 3'd0) begin
            if (draw_fits) begin
              need_q  <= draw_n;
              draw_q  <= i_req_draw;
              state_q <= S_REQ;
            end else begin
              draw_err_q <= 1'b1;
            end
          end else if (i_play) begin
            if (legal) begin
              played_q  <= sel_card;
              play_ok_q <= 1'b1;
              count_q   <= count_q - CNT_W'(1);
              if (sel_is_last) begin
                hand_q[i_sel] <= '0;
              end else begin
                k_q     <= i_sel;
                state_q <= S_SHIFT;
              end
            end else begin
              play_err_q <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (deck.i_deck_done) state_q <= S_RECV;
        end

        S_RECV: begin
          if (deck.i_drawn) begin
            hand_q[count_q[IDX_W-1:0]] <= deck.i_card;
            count_q <= count_q + CNT_W'(1);
            need_q  <= need_q - 3'd1;
            if (need_q == 3'd1) begin
              draw_q  <= '0;
              state_q <= S_IDLE;
            end
          end
        end

        S_SHIFT: begin
          hand_q[k_q] <= hand_q[k_q + IDX_W'(1)];
          k_q         <= k_q + IDX_W'(1);
          if (shift_last) begin
            hand_q[k_q + IDX_W'(1)] <= '0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign deck.o_draw   = draw_q;
  assign o_sel_card    = sel_valid ? sel_card : card_t'('0);
  assign o_played_card = played_q;
  assign o_play_ok     = play_ok_q;
  assign o_play_err    = play_err_q;
  assign o_draw_err    = draw_err_q;
  assign o_busy        = state_q != S_IDLE;
  assign o_count       = count_q;
  assign o_uno         = count_q == CNT_W'(1);
  assign o_empty       = count_q == '0;
  assign o_dbg_state   = state_q;

endmodule
